// File: rtl/exp5_mostra_sequencia.sv
// Memory-game sequence presenter: shows ROM entries 0..limite on the LEDs, each lit for T_ON cycles then dark for T_OFF.
// Optional macro EXP5_ABORTA_EN adds an `abortar` input that cancels a presentation in progress.
module exp5_mostra_sequencia #(
  parameter int T_ON  = 1000,
  parameter int T_OFF = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mostrar,
`ifdef EXP5_ABORTA_EN
  input  logic       abortar,
`endif
  input  logic [3:0] limite,
  input  logic [3:0] mem_dado,
  output logic [3:0] mem_endereco,
  output logic [3:0] leds,
  output logic       ativo,
  output logic       pronto,
  output logic [3:0] db_indice,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    PREPARA = 4'h1,
    ACENDE  = 4'h2,
    APAGA   = 4'h3,
    PROXIMO = 4'h4,
    FIM     = 4'hF
  } estado_t;

  localparam logic [15:0] TON_FIM  = 16'(T_ON - 1);
  localparam logic [15:0] TOFF_FIM = 16'(T_OFF - 1);

  estado_t     estado, estado_prox;
  logic [3:0]  indice;
  logic [3:0]  limite_reg;
  logic [15:0] timer;
  logic [3:0]  leds_reg;
  logic        fim_on, fim_off, ultimo, aborta;

  assign fim_on  = (timer == TON_FIM);
  assign fim_off = (timer == TOFF_FIM);
  assign ultimo  = (indice == limite_reg);

`ifdef EXP5_ABORTA_EN
  assign aborta = abortar && (estado != INICIAL);
`else
  assign aborta = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= estado_prox;
  end

  always_comb begin
    estado_prox = INICIAL;
    case (estado)
      INICIAL: estado_prox = mostrar ? PREPARA : INICIAL;
      PREPARA: estado_prox = ACENDE;
      ACENDE:  estado_prox = fim_on ? APAGA : ACENDE;
      APAGA:   estado_prox = !fim_off ? APAGA : (ultimo ? FIM : PROXIMO);
      PROXIMO: estado_prox = ACENDE;
      FIM:     estado_prox = INICIAL;
      default: estado_prox = INICIAL;
    endcase
    if (aborta) estado_prox = INICIAL;
  end

  // The index advances on the edge into PROXIMO so the ROM already presents
  // the next entry there and the LED register can load it on the exit edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      indice     <= 4'd0;
      limite_reg <= 4'd0;
      timer      <= 16'd0;
      leds_reg   <= 4'd0;
    end else if (aborta) begin
      indice   <= 4'd0;
      timer    <= 16'd0;
      leds_reg <= 4'd0;
    end else begin
      case (estado)
        PREPARA: begin
          indice     <= 4'd0;
          timer      <= 16'd0;
          limite_reg <= limite;
          leds_reg   <= mem_dado;
        end
        ACENDE: begin
          if (fim_on) begin
            timer    <= 16'd0;
            leds_reg <= 4'd0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        APAGA: begin
          if (fim_off) begin
            timer <= 16'd0;
            if (!ultimo) indice <= indice + 4'd1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        PROXIMO: begin
          timer    <= 16'd0;
          leds_reg <= mem_dado;
        end
        FIM: begin
          indice <= 4'd0;
          timer  <= 16'd0;
        end
        default: begin
          indice   <= 4'd0;
          timer    <= 16'd0;
          leds_reg <= 4'd0;
        end
      endcase
    end
  end

  assign mem_endereco = indice;
  assign db_indice    = indice;
  assign leds         = leds_reg;
  assign db_estado    = estado;
  assign ativo        = (estado != INICIAL);
  assign pronto       = (estado == FIM);

endmodule

// File: tb/tb_exp5_mostra_sequencia.sv
// Bench for exp5_mostra_sequencia: random ROM contents and limits compared cycle by cycle
// against an expected display timeline built from the presentation rules.
module tb_exp5_mostra_sequencia;
  localparam int T_ON  = 4;
  localparam int T_OFF = 2;

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic       mostrar = 1'b0;
  logic [3:0] limite  = 4'd0;
`ifdef EXP5_ABORTA_EN
  logic       abortar = 1'b0;
`endif
  logic [3:0] mem_dado, mem_endereco, leds, db_indice, db_estado;
  logic       ativo, pronto;
  logic [3:0] rom [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] st;
    logic [3:0] led;
    logic [3:0] idx;
    bit         idx_ok;
  } exp_t;

  exp_t model[$];

  always #5 clock = ~clock;

  assign mem_dado = rom[mem_endereco];

  exp5_mostra_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
    .clock       (clock),
    .reset       (reset),
    .mostrar     (mostrar),
`ifdef EXP5_ABORTA_EN
    .abortar     (abortar),
`endif
    .limite      (limite),
    .mem_dado    (mem_dado),
    .mem_endereco(mem_endereco),
    .leds        (leds),
    .ativo       (ativo),
    .pronto      (pronto),
    .db_indice   (db_indice),
    .db_estado   (db_estado)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected timeline, one entry per cycle after the sampling edge of mostrar.
  task automatic build_model(input int lim);
    exp_t e;
    model.delete();
    e = '{4'h1, 4'h0, 4'h0, 1'b1};
    model.push_back(e);
    for (int i = 0; i <= lim; i++) begin
      for (int t = 0; t < T_ON; t++) begin
        e = '{4'h2, rom[i], 4'(i), 1'b1};
        model.push_back(e);
      end
      for (int t = 0; t < T_OFF; t++) begin
        e = '{4'h3, 4'h0, 4'(i), 1'b1};
        model.push_back(e);
      end
      if (i < lim) begin
        e = '{4'h4, 4'h0, 4'h0, 1'b0};
        model.push_back(e);
      end
    end
    e = '{4'hF, 4'h0, 4'(lim), 1'b1};
    model.push_back(e);
    e = '{4'h0, 4'h0, 4'h0, 1'b1};
    model.push_back(e);
  endtask

  task automatic start_show(input int lim);
    limite = 4'(lim);
    @(posedge clock);
    #1 mostrar = 1'b1;
    @(posedge clock);
    #1 mostrar = 1'b0;
  endtask

  task automatic run_show(input int lim, input bit perturb);
    int n_pronto;
    string tg;
    n_pronto = 0;
    build_model(lim);
    start_show(lim);
    for (int c = 0; c < model.size(); c++) begin
      @(negedge clock);
      tg = $sformatf("L%0d c%0d", lim, c + 1);
      check({tg, " estado"}, db_estado, model[c].st);
      check({tg, " leds"}, leds, model[c].led);
      check({tg, " ativo"}, ativo, model[c].st != 4'h0);
      check({tg, " pronto"}, pronto, model[c].st == 4'hF);
      if (model[c].idx_ok) begin
        check({tg, " indice"}, db_indice, model[c].idx);
        check({tg, " endereco"}, mem_endereco, model[c].idx);
      end
      if (pronto === 1'b1) n_pronto++;
      if (perturb) begin
        mostrar = (model[c].st == 4'h3) && (c > 0) && (model[c-1].st == 4'h2);
        if (model[c].st == 4'h2) limite = 4'($urandom_range(0, 15));
      end
    end
    mostrar = 1'b0;
    check($sformatf("L%0d pronto_count", lim), n_pronto, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));

    #2;
    check("rst estado", db_estado, 4'h0);
    check("rst leds", leds, 4'h0);
    check("rst endereco", mem_endereco, 4'h0);
    check("rst indice", db_indice, 4'h0);
    check("rst ativo", ativo, 1'b0);
    check("rst pronto", pronto, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    run_show(0, 1'b0);
    run_show(2, 1'b0);
    run_show(2, 1'b1);

    for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
    run_show(15, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
      run_show($urandom_range(0, 15), $urandom_range(0, 1) == 1);
    end

    // Asynchronous reset in the middle of ACENDE
    for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));
    start_show(3);
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("mid_rst estado", db_estado, 4'h0);
    check("mid_rst leds", leds, 4'h0);
    check("mid_rst endereco", mem_endereco, 4'h0);
    check("mid_rst indice", db_indice, 4'h0);
    check("mid_rst ativo", ativo, 1'b0);
    check("mid_rst pronto", pronto, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      check($sformatf("post_rst c%0d estado", c), db_estado, 4'h0);
      check($sformatf("post_rst c%0d pronto", c), pronto, 1'b0);
    end

`ifdef EXP5_ABORTA_EN
    start_show(2);
    repeat (3) @(negedge clock);
    check("abort pre estado", db_estado, 4'h2);
    abortar = 1'b1;
    @(negedge clock);
    abortar = 1'b0;
    check("abort estado", db_estado, 4'h0);
    check("abort leds", leds, 4'h0);
    check("abort ativo", ativo, 1'b0);
    check("abort indice", db_indice, 4'h0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      check($sformatf("post_abort c%0d pronto", c), pronto, 1'b0);
      check($sformatf("post_abort c%0d estado", c), db_estado, 4'h0);
    end
    run_show(1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp5_mostra_sequencia.md
# exp5_mostra_sequencia

Sequence presenter for the memory game: reads the stored sequence from the game ROM entry by entry and drives each value onto the LEDs for a fixed on-time, followed by a blank gap. It is the transmit side of the play/compare path. The game controller asks it to show positions 0..limite, waits for `pronto`, then hands over to the player-input and compare logic. The presenter shares the ROM address bus with the data path under controller arbitration and asserts `ativo` while it owns the bus.

## Interface
Parameters:
- `T_ON`, 1000: clock cycles each value stays lit; legal range 1..65535.
- `T_OFF`, 500: clock cycles of blank LEDs after each value; legal range 1..65535.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset; `reset`=0 clears all state immediately.
- `mostrar` in 1: start request, sampled only in INICIAL.
- `limite` in 4: index of the last position to show, inclusive; captured in PREPARA.
- `mem_dado` in 4: ROM read data, combinational from `mem_endereco`.
- `mem_endereco` out 4: ROM address; equals the current index.
- `leds` out 4: displayed value, registered.
- `ativo` out 1: 1 in every state except INICIAL.
- `pronto` out 1: one-cycle pulse in FIM.
- `db_indice` out 4: current index, for the hexa7seg display.
- `db_estado` out 4: state code, for the hexa7seg display.

## Operation
- Controller is Moore-style. Datapath has a 4-bit index register, a 4-bit limit register, a 16-bit timer and a 4-bit LED register.
- INICIAL (0x0):
  - Index 0, timer 0, `leds`=0.
  - Goes to PREPARA when `mostrar`=1.
- PREPARA (0x1):
  - Clears index and timer and loads the limit register from `limite`.
  - Always goes to ACENDE.
  - The LED register loads `mem_dado` (address 0) on this exit edge.
- ACENDE (0x2):
  - `leds` holds the loaded value. The timer counts up.
  - When timer = T_ON-1, clears the timer, loads `leds`=0 and goes to APAGA.
- APAGA (0x3):
  - Timer counts up.
  - When timer = T_OFF-1, clears the timer.
  - If index = limit, goes to FIM. Otherwise goes to PROXIMO.
- PROXIMO (0x4):
  - Index increments.
  - Goes to ACENDE. The LED register loads `mem_dado` at the new address on the exit edge.
- FIM (0xF):
  - `pronto`=1 for this cycle only.
  - Returns unconditionally to INICIAL.
- Undefined state codes go to INICIAL.
- `mem_endereco` = index register at all times.
- Index is 4-bit and never wraps: at most 16 entries are shown, when `limite`=15.
- A stored value of 0 displays as dark LEDs, identical to the gap; this is intentional.
- `mostrar` outside INICIAL is ignored. `limite` changes after PREPARA have no effect.
- `mostrar` held high re-triggers a new presentation right after FIM→INICIAL.

## Timing
- Reset values: `leds`=0, `mem_endereco`=0, `db_indice`=0, `db_estado`=0x0, `ativo`=0, `pronto`=0.
- Reset mid-presentation aborts at once; no `pronto` is produced.
- Latency: with `mostrar` sampled at edge k, PREPARA is active in cycle k+1 and the first value appears on `leds` in cycle k+2.
- Per shown entry: T_ON lit cycles, then T_OFF dark cycles, plus 1 PROXIMO cycle between entries.
- Total from sampling edge to FIM: 1 + (L+1)·(T_ON+T_OFF) + L cycles, with L = limit. FIM lasts 1 cycle.
- `pronto` and `ativo` are both high in FIM. `ativo` falls on the next edge.

## Configuration
- `EXP5_ABORTA_EN` defined:
  - Adds input port `abortar` (1 bit).
  - `abortar`=1 in any state other than INICIAL forces INICIAL on the next edge, clears index and timer and sets `leds`=0.
  - No `pronto` pulse is produced.
  - `abortar` has priority over all other transitions.
- Not defined: the port does not exist and a presentation always runs to FIM.

## Test plan
All scenarios use T_ON=4, T_OFF=2, with ROM[0..3] = 1, 2, 4, 8.
- Pulse `reset`=0 mid-ACENDE → all outputs zero in the same cycle; after release, state stays 0x0 with no `pronto`.
- `limite`=0, pulse `mostrar` → `leds`=1 for 4 cycles, 0 for 2 cycles, `pronto` in cycle 8 after the sampling edge; state trace is 1,2,2,2,2,3,3,F.
- `limite`=2 → `leds` sequence 1,2,4, each 4 cycles wide, with 2-cycle gaps and 1 extra dark PROXIMO cycle between entries; `pronto` at cycle 22; `mem_endereco` steps 0→1→2.
- `limite`=15 with full ROM → 16 entries shown; `db_indice` ends at 15 without wrap; exactly one `pronto` pulse.
- `mostrar` pulsed during APAGA, and `limite` changed during ACENDE → no effect on the sequence or on the count of shown entries.
- With `EXP5_ABORTA_EN` defined: `abortar` in the second ACENDE cycle → next cycle state 0x0, `leds`=0, `ativo`=0, `pronto` never asserted.
